// File: rtl/oclib_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oclib_fifo_write_arbiter
// Purpose  : Packet-aware round-robin arbiter that shares the write side of
//            a single FIFO among Inputs requesters. A grant is held until the
//            packet's last beat or until MaxBurst beats have been accepted.
//            New grants are withheld while the FIFO reports almostFull.
//            Output is a single register stage feeding FIFO inData/inValid.
// Options  : define OCLIB_FIFO_ARB_TAG_EN to append the source index
//            (IdxWidth bits) above the data bits of outData.
// Revision : 1.0 - initial release
// ============================================================================
module oclib_fifo_write_arbiter #(
  parameter  int Inputs   = 4,
  parameter  int Width    = 32,
  parameter  int MaxBurst = 16,
  localparam int IdxWidth = $clog2(Inputs),
`ifdef OCLIB_FIFO_ARB_TAG_EN
  localparam int OutWidth = Width + IdxWidth
`else
  localparam int OutWidth = Width
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [Inputs*Width-1:0]   reqData,
  input  logic [Inputs-1:0]         reqLast,
  input  logic [Inputs-1:0]         reqValid,
  output logic [Inputs-1:0]         reqReady,
  input  logic                      fifoAlmostFull,
  output logic [OutWidth-1:0]       outData,
  output logic                      outLast,
  output logic                      outValid,
  input  logic                      outReady,
  output logic                      grantActive,
  output logic [IdxWidth-1:0]       grantIndex
);

  // Counter must be at least one bit wide even when bursts are unlimited.
  localparam int c_countWidth = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [IdxWidth-1:0]     r_grantIndex;
  logic [IdxWidth-1:0]     w_pickIndex;
  logic [IdxWidth-1:0]     w_cand;
  logic                    w_pickValid;
  logic [c_countWidth-1:0] r_beatCount;
  logic                    w_outFree;
  logic                    w_accept;
  logic                    w_release;
  logic                    w_burstEnd;
  logic [Width-1:0]        w_beatData;
  logic [OutWidth-1:0]     w_beatWord;

  assign grantIndex  = r_grantIndex;
  assign grantActive = (r_state == StGrant);

  // Round-robin search: first valid requester after the pointer, wrapping
  // modulo Inputs so indices >= Inputs are never produced.
  always_comb begin
    w_pickValid = 1'b0;
    w_pickIndex = r_grantIndex;
    w_cand      = '0;
    for (int k = 1; k <= Inputs; k++) begin
      w_cand = IdxWidth'((int'(r_grantIndex) + k) % Inputs);
      if (!w_pickValid && reqValid[w_cand]) begin
        w_pickValid = 1'b1;
        w_pickIndex = w_cand;
      end
    end
  end

  // Selected requester's beat, optionally tagged with its index.
  always_comb begin
    w_beatData = reqData[int'(r_grantIndex)*Width +: Width];
`ifdef OCLIB_FIFO_ARB_TAG_EN
    w_beatWord = {r_grantIndex, w_beatData};
`else
    w_beatWord = w_beatData;
`endif
  end

  // Next-state, handshake and release decode.
  always_comb begin
    w_stateNext = r_state;
    reqReady    = '0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_outFree   = !outValid || outReady;
    // Release on the MaxBurst-th beat: counter holds beats already taken.
    w_burstEnd  = (MaxBurst != 0) &&
                  (r_beatCount == c_countWidth'(MaxBurst - 1));
    case (r_state)
      StIdle: begin
        // almostFull only gates new grants, never an active one.
        if (!fifoAlmostFull && w_pickValid) begin
          w_stateNext = StGrant;
        end
      end
      StGrant: begin
        reqReady[r_grantIndex] = w_outFree;
        w_accept  = reqValid[r_grantIndex] && w_outFree;
        w_release = w_accept && (reqLast[r_grantIndex] || w_burstEnd);
        if (w_release) begin
          w_stateNext = StIdle;
        end
      end
      default: w_stateNext = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Grant pointer and per-grant beat counter; pointer survives release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grantIndex <= IdxWidth'(Inputs - 1);
      r_beatCount  <= '0;
    end else if (r_state == StIdle && w_stateNext == StGrant) begin
      r_grantIndex <= w_pickIndex;
      r_beatCount  <= '0;
    end else if (w_accept) begin
      r_beatCount  <= r_beatCount + 1'b1;
    end
  end

  // Output register: load on accept, otherwise drain when FIFO takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid <= 1'b0;
      outData  <= '0;
      outLast  <= 1'b0;
    end else if (w_accept) begin
      outValid <= 1'b1;
      outData  <= w_beatWord;
      outLast  <= reqLast[r_grantIndex] || w_burstEnd;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oclib_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_oclib_fifo_write_arbiter
// Purpose  : Self-checking bench for oclib_fifo_write_arbiter. A behavioural
//            model (owner / beat count / pointer) predicts every cycle, and a
//            beat scoreboard tracks what must leave the output register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oclib_fifo_write_arbiter;

  localparam int Inputs   = 4;
  localparam int Width    = 32;
  localparam int MaxBurst = 16;
  localparam int IdxWidth = $clog2(Inputs);
`ifdef OCLIB_FIFO_ARB_TAG_EN
  localparam int OutWidth = Width + IdxWidth;
`else
  localparam int OutWidth = Width;
`endif
  localparam int Depth = 512;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [Inputs*Width-1:0] reqData;
  logic [Inputs-1:0]       reqLast;
  logic [Inputs-1:0]       reqValid;
  logic [Inputs-1:0]       reqReady;
  logic                    fifoAlmostFull;
  logic [OutWidth-1:0]     outData;
  logic                    outLast;
  logic                    outValid;
  logic                    outReady;
  logic                    grantActive;
  logic [IdxWidth-1:0]     grantIndex;

  oclib_fifo_write_arbiter #(
    .Inputs  (Inputs),
    .Width   (Width),
    .MaxBurst(MaxBurst)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .reqData       (reqData),
    .reqLast       (reqLast),
    .reqValid      (reqValid),
    .reqReady      (reqReady),
    .fifoAlmostFull(fifoAlmostFull),
    .outData       (outData),
    .outLast       (outLast),
    .outValid      (outValid),
    .outReady      (outReady),
    .grantActive   (grantActive),
    .grantIndex    (grantIndex)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-requester beat sources {last, data}.
  logic [Width:0]  srcMem [Inputs][Depth];
  int              head [Inputs];
  int              tail [Inputs];
  logic [Inputs-1:0] en;

  // Observed output handshakes.
  logic [Width-1:0] obsData[$];
  logic             obsLast[$];
  int               obsCyc[$];
  logic [OutWidth:0] sbQ[$];

  // Behavioural model state.
  bit                  mBusy;
  int                  mOwner;
  int                  mBeats;
  int                  mPtr;
  bit                  mOutValid;
  bit                  mOutLast;
  logic [OutWidth-1:0] mOutData;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic pushBeat(input int src, input logic [Width-1:0] d, input logic last);
    srcMem[src][tail[src] % Depth] = {last, d};
    tail[src]++;
  endtask

  task automatic pushPkt(input int src, input int len, input logic [Width-1:0] base);
    for (int j = 0; j < len; j++) pushBeat(src, base + Width'(j), j == len - 1);
  endtask

  task automatic driveInputs();
    logic [Width:0] w;
    for (int i = 0; i < Inputs; i++) begin
      w = srcMem[i][head[i] % Depth];
      reqValid[i] = (head[i] != tail[i]) && en[i];
      reqData[i*Width +: Width] = w[Width-1:0];
      reqLast[i] = w[Width];
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mOwner = 0; mBeats = 0; mPtr = Inputs - 1;
    mOutValid = 0; mOutLast = 0; mOutData = '0;
    sbQ.delete(); obsData.delete(); obsLast.delete(); obsCyc.delete();
    for (int i = 0; i < Inputs; i++) begin
      head[i] = 0; tail[i] = 0;
      srcMem[i][0] = '0;
    end
  endtask

  // One clock of the model: beat accepted by the owner moves to the output
  // register; an idle cycle grants the first valid requester after the pointer.
  task automatic modelStep();
    bit readyNow, take, wasBusy, lastB;
    int c;
    logic [Width-1:0] d;
    logic [OutWidth-1:0] word;
    wasBusy  = mBusy;
    readyNow = !mOutValid || outReady;
    take     = mBusy && reqValid[mOwner] && readyNow;
    if (take) begin
      d = reqData[mOwner*Width +: Width];
      lastB = reqLast[mOwner] || (MaxBurst != 0 && mBeats + 1 == MaxBurst);
`ifdef OCLIB_FIFO_ARB_TAG_EN
      word = {IdxWidth'(mOwner), d};
`else
      word = d;
`endif
      mOutValid = 1; mOutData = word; mOutLast = lastB;
      sbQ.push_back({lastB, word});
      head[mOwner]++;
      mBeats++;
      if (lastB) mBusy = 0;
    end else if (outReady) begin
      mOutValid = 0;
    end
    if (!wasBusy && !fifoAlmostFull) begin
      for (int k = 1; k <= Inputs; k++) begin
        c = (mPtr + k) % Inputs;
        if (!mBusy && reqValid[c]) begin
          mBusy = 1; mOwner = c; mPtr = c; mBeats = 0;
        end
      end
    end
  endtask

  task automatic checkOutputs();
    logic [Inputs-1:0] expReady;
    logic [OutWidth:0] e;
    expReady = (mBusy && (!mOutValid || outReady)) ? (Inputs'(1) << mOwner) : '0;
    checkValue("outValid", outValid, mOutValid);
    checkValue("reqReady", reqReady, expReady);
    checkValue("grantActive", grantActive, mBusy);
    checkValue("grantIndex", grantIndex, mPtr);
    if (mOutValid) begin
      checkValue("outData", outData, mOutData);
      checkValue("outLast", outLast, mOutLast);
    end
    if (outValid && outReady) begin
      if (sbQ.size() == 0) begin
        checkValue("sb_extra", 1, 0);
      end else begin
        e = sbQ.pop_front();
        checkValue("sb_data", outData, e[OutWidth-1:0]);
        checkValue("sb_last", outLast, e[OutWidth]);
      end
      obsData.push_back(outData[Width-1:0]);
      obsLast.push_back(outLast);
      obsCyc.push_back(cyc);
    end
  endtask

  task automatic cycle();
    driveInputs();
    @(negedge clock);
    checkOutputs();
    @(posedge clock);
    modelStep();
    cyc++;
    #1;
  endtask

  task automatic checkResetState(input string tg);
    checkValue({tg, "_outValid"}, outValid, 0);
    checkValue({tg, "_reqReady"}, reqReady, 0);
    checkValue({tg, "_grantActive"}, grantActive, 0);
    checkValue({tg, "_grantIndex"}, grantIndex, Inputs - 1);
    checkValue({tg, "_outData"}, outData, 0);
    checkValue({tg, "_outLast"}, outLast, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic doReset(input string tg);
    #2;
    reset = 1'b1;
    #1;
    checkResetState(tg);
    modelReset();
    en = '1;
    driveInputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    modelStep();
    cyc++;
    #1;
  endtask

  initial begin
    int lastCnt;
    bit reached;
    reset = 1'b1;
    fifoAlmostFull = 1'b0;
    outReady = 1'b1;
    en = '1;
    reqData = '0; reqLast = '0; reqValid = '0;
    modelReset();
    #2;
    checkResetState("por");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    modelStep();
    #1;

    // Two 3-beat packets from req0 and req2.
    pushPkt(0, 3, 32'h0000_0000);
    pushPkt(2, 3, 32'h0200_0000);
    repeat (16) cycle();
    checkValue("s1_count", obsData.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < obsData.size()) checkValue("s1_src", obsData[k][Width-1 -: 8], (k < 3) ? 0 : 2);
    if (obsCyc.size() >= 4) begin
      checkValue("s1_back2back", obsCyc[1] - obsCyc[0], 1);
      checkValue("s1_idle_gap", obsCyc[3] - obsCyc[2], 2);
    end

    // Everyone valid with 1-beat packets: strict rotation, one beat / 2 clks.
    doReset("rst2");
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < Inputs; i++) pushPkt(i, 1, Width'(i << 24) + Width'(j));
    repeat (30) cycle();
    checkValue("s2_count", obsData.size(), 12);
    for (int k = 0; k < obsData.size(); k++) begin
      checkValue("s2_order", obsData[k][Width-1 -: 8], k % Inputs);
      if (k > 0) checkValue("s2_rate", obsCyc[k] - obsCyc[k-1], 2);
    end

    // 40 beats without last: forced releases on beats 16 and 32.
    doReset("rst3");
    for (int j = 0; j < 40; j++) pushBeat(1, 32'h0100_0000 + Width'(j), 1'b0);
    repeat (100) cycle();
    checkValue("s3_count", obsData.size(), 40);
    lastCnt = 0;
    foreach (obsLast[k]) if (obsLast[k]) lastCnt++;
    checkValue("s3_lastcnt", lastCnt, 2);
    if (obsLast.size() >= 40) begin
      checkValue("s3_last16", obsLast[15], 1);
      checkValue("s3_last32", obsLast[31], 1);
      checkValue("s3_last40", obsLast[39], 0);
    end

    // Random back-pressure during a 5-beat packet A0..A4.
    doReset("rst4");
    pushPkt(0, 5, 32'h0000_00A0);
    for (int t = 0; t < 200 && obsData.size() < 5; t++) begin
      outReady = ($urandom % 2) == 1;
      cycle();
    end
    outReady = 1'b1;
    repeat (3) cycle();
    checkValue("s4_count", obsData.size(), 5);
    for (int k = 0; k < obsData.size(); k++) checkValue("s4_seq", obsData[k], 32'hA0 + k);

    // almostFull blocks new grants but not a held one.
    doReset("rst5");
    fifoAlmostFull = 1'b1;
    pushPkt(3, 4, 32'h0300_0000);
    repeat (5) cycle();
    checkValue("s5_blocked", grantActive, 0);
    fifoAlmostFull = 1'b0;
    cycle();
    checkValue("s5_grantActive", grantActive, 1);
    checkValue("s5_grantIndex", grantIndex, 3);
    fifoAlmostFull = 1'b1;
    repeat (10) cycle();
    checkValue("s5_complete", obsData.size(), 4);
    fifoAlmostFull = 1'b0;

    // Reset during beat 2 of 4, then requester 0 wins again.
    doReset("rst6");
    pushPkt(0, 4, 32'h0000_0010);
    pushPkt(1, 2, 32'h0100_0010);
    reached = 0;
    for (int t = 0; t < 20 && !reached; t++) begin
      cycle();
      reached = mBusy && mOwner == 0 && mBeats == 1;
    end
    checkValue("s6_reached", reached, 1);
    doReset("mid");
    pushPkt(3, 1, 32'h0300_0020);
    pushPkt(0, 1, 32'h0000_0020);
    repeat (8) cycle();
    checkValue("s6_count", obsData.size(), 2);
    if (obsData.size() > 0) checkValue("s6_first", obsData[0][Width-1 -: 8], 0);

    // Randomized traffic, back-pressure and almostFull.
    doReset("rst7");
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < Inputs; i++) begin
        if (head[i] == tail[i] && ($urandom % 4) == 0)
          pushPkt(i, 1 + int'($urandom % 20), Width'(i << 24) + Width'(t << 5));
        en[i] = ($urandom % 100) < 75;
      end
      outReady       = ($urandom % 100) < 70;
      fifoAlmostFull = ($urandom % 100) < 10;
      cycle();
    end
    en = '1; outReady = 1'b1; fifoAlmostFull = 1'b0;
    repeat (400) cycle();
    begin
      int pend;
      pend = 0;
      for (int i = 0; i < Inputs; i++) pend += tail[i] - head[i];
      checkValue("s7_src_drained", pend, 0);
    end
    checkValue("s7_sb_drained", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
